// File: rtl/video_source_fader.sv
// Frame-synchronous RGB source selector with a fade-to-black transition.
// The old source dims over 2^FADE_LOG2 frames, then the new one brightens back.
module video_source_fader #(
  parameter  int NUM_SRC   = 8,
  parameter  int COLOR_W   = 8,
  parameter  int FADE_LOG2 = 2,
  parameter  int COORD_W   = 11,
  localparam int SW        = $clog2(NUM_SRC)
) (
  input  logic                       iCLK_50M,
  input  logic                       iRST_N,
  input  logic [NUM_SRC*COLOR_W-1:0] iSrc_R,
  input  logic [NUM_SRC*COLOR_W-1:0] iSrc_G,
  input  logic [NUM_SRC*COLOR_W-1:0] iSrc_B,
  input  logic [SW-1:0]              iSel,
  input  logic [COORD_W-1:0]         iCurrent_Y,
  output logic [COLOR_W-1:0]         oRed,
  output logic [COLOR_W-1:0]         oGreen,
  output logic [COLOR_W-1:0]         oBlue,
  output logic [SW-1:0]              oActive_Src,
  output logic                       oBusy
);

  localparam int LW = FADE_LOG2 + 1;
  localparam int PW = COLOR_W + FADE_LOG2 + 1;
  localparam logic [LW-1:0] FULL = LW'(1 << FADE_LOG2);

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } state_t;

  state_t               state_q;
  logic [SW-1:0]        s1_q, s2_q;
  logic [SW-1:0]        active_q, target_q;
  logic [LW-1:0]        level_q;
  logic [COORD_W-1:0]   prev_y_q;
  logic [COLOR_W-1:0]   r_q, g_q, b_q;
  logic                 busy_q;

  logic [SW-1:0]        sel_s;
  logic                 tick;
  logic [LW-1:0]        lvl_dn, lvl_up;

  // Out-of-range requests fall back to source 0.
  assign sel_s  = (32'(s2_q) >= NUM_SRC) ? '0 : s2_q;
  assign tick   = (prev_y_q != '0) && (iCurrent_Y == '0);
  assign lvl_dn = level_q - LW'(1);
  assign lvl_up = level_q + LW'(1);

  function automatic logic [COLOR_W-1:0] scale(
    input logic [COLOR_W-1:0] p,
    input logic [LW-1:0]      l
  );
    logic [PW-1:0] prod;
    prod = PW'(p) * PW'(l);
    return COLOR_W'(prod >> FADE_LOG2);
  endfunction

  always_ff @(posedge iCLK_50M or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      s1_q     <= '0;
      s2_q     <= '0;
      active_q <= '0;
      target_q <= '0;
      level_q  <= FULL;
      prev_y_q <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
    end else begin
      s1_q     <= iSel;
      s2_q     <= s1_q;
      prev_y_q <= iCurrent_Y;
      r_q <= scale(iSrc_R[32'(active_q)*COLOR_W +: COLOR_W], level_q);
      g_q <= scale(iSrc_G[32'(active_q)*COLOR_W +: COLOR_W], level_q);
      b_q <= scale(iSrc_B[32'(active_q)*COLOR_W +: COLOR_W], level_q);
      if (tick) begin
        unique case (state_q)
          IDLE: begin
            if (sel_s != active_q) begin
              if (FADE_LOG2 == 0) begin
                active_q <= sel_s;
              end else begin
                target_q <= sel_s;
                level_q  <= lvl_dn;
                state_q  <= FADE_OUT;
                busy_q   <= 1'b1;
              end
            end
          end
          FADE_OUT: begin
            level_q  <= lvl_dn;
            target_q <= sel_s;
            // A withdrawn request wins over a swap on the same tick.
            if (sel_s == active_q) begin
              state_q <= FADE_IN;
            end else if (lvl_dn == '0) begin
              active_q <= sel_s;
              state_q  <= FADE_IN;
            end
          end
          FADE_IN: begin
            level_q <= lvl_up;
            if (lvl_up == FULL) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign oRed        = r_q;
  assign oGreen      = g_q;
  assign oBlue       = b_q;
  assign oActive_Src = active_q;
  assign oBusy       = busy_q;

endmodule
